// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer timer path.
//   - state_e          : timer FSM encoding (CLEAR=0, RUN=1, EXPIRED=2)
//   - DEF_PERIOD       : default debounce period in ticks
//   - DEF_CYCLES_PER_TICK : default clock cycles per tick (1 ms at 100 MHz)
//   - cnt_width()      : ceil(log2(n)) with a minimum of 1
package debounce_pkg;

    typedef enum logic [1:0] {
        StClear   = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } state_e;

    localparam int unsigned DEF_PERIOD          = 20;
    localparam int unsigned DEF_CYCLES_PER_TICK = 100000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Cycle prescaler producing one interval tick every CYCLES_PER_TICK enabled cycles.
// Ports:
//   clk    in  : system clock
//   reset  in  : asynchronous active-high reset
//   clear  in  : synchronous clear of the cycle count (wins over enable)
//   enable in  : count this cycle
//   tick   out : high on the enabled cycle that completes a tick
module tick_prescaler
    import debounce_pkg::*;
#(
    parameter int unsigned CYCLES_PER_TICK = DEF_CYCLES_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = cnt_width(CYCLES_PER_TICK);
    localparam logic [CntW-1:0] TermCnt = CntW'(CYCLES_PER_TICK - 1);

    logic [CntW-1:0] cnt_q;

    // Combinational tick so the edge that completes the count is the tick edge.
    assign tick = enable && !clear && (cnt_q == TermCnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_timer.sv
// Debounce interval timer answering the debouncer FSM's timer handshake.
// timer_done rises after period * CYCLES_PER_TICK consecutive edges with timer_reset low.
// Ports:
//   clk         in  : system clock
//   reset       in  : asynchronous active-high reset
//   timer_reset in  : high clears and holds the timer, low lets it run
//   period_in   in  : new period in ticks (0 is stored as 1)
//   period_load in  : strobe latching period_in, honoured only in CLEAR
//   timer_done  out : sticky interval-elapsed flag, cleared by timer_reset
//   busy        out : high while in RUN
//   elapsed     out : ticks completed in the current run
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int unsigned CYCLES_PER_TICK = DEF_CYCLES_PER_TICK,
    parameter int unsigned PERIOD_W        = 8,
    parameter int unsigned DEFAULT_PERIOD  = DEF_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                timer_reset,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_load,
    output logic                timer_done,
    output logic                busy,
    output logic [PERIOD_W-1:0] elapsed
);

    state_e              state_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                done_q;
    logic                busy_q;

    logic                tick;
    logic                presc_enable;
    logic                load_ok;
    logic [PERIOD_W-1:0] load_val;
    logic [PERIOD_W-1:0] eff_period;
    logic [PERIOD_W-1:0] count_inc;

    // Prescaler runs on the CLEAR->RUN edge and throughout RUN; frozen in EXPIRED.
    assign presc_enable = !timer_reset && (state_q != StExpired);

    tick_prescaler #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (timer_reset),
        .enable(presc_enable),
        .tick  (tick)
    );

    always_comb begin
        load_val   = (period_in == '0) ? PERIOD_W'(1) : period_in;
        load_ok    = period_load && (state_q == StClear);
        // A load on the CLEAR->RUN edge already governs the run it starts.
        eff_period = load_ok ? load_val : period_q;
        count_inc  = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StClear;
            period_q <= PERIOD_W'(DEFAULT_PERIOD);
            count_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (load_ok) begin
                period_q <= load_val;
            end
            if (timer_reset) begin
                state_q <= StClear;
                count_q <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StClear, StRun: begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        if (tick) begin
                            count_q <= count_inc;
                            if (count_inc == eff_period) begin
                                state_q <= StExpired;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    StExpired: begin
                        // Counters frozen, done held until timer_reset.
                    end
                    default: begin
                        state_q <= StClear;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign timer_done = done_q;
    assign busy       = busy_q;
    assign elapsed    = count_q;

endmodule

// File: tb/tb_debounce_timer.sv
module tb_debounce_timer;

    localparam int unsigned CPT = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned DP  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          timer_reset;
    logic [PW-1:0] period_in;
    logic          period_load;
    logic          timer_done;
    logic          busy;
    logic [PW-1:0] elapsed;

    debounce_timer #(
        .CYCLES_PER_TICK(CPT),
        .PERIOD_W       (PW),
        .DEFAULT_PERIOD (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_reset(timer_reset),
        .period_in  (period_in),
        .period_load(period_load),
        .timer_done (timer_done),
        .busy       (busy),
        .elapsed    (elapsed)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned elapsed;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expect timer_done to rise N edges after the edge count at this moment.
    task automatic expect_done(input string name, input int unsigned n, input int unsigned el);
        exp_t e;
        e.cyc     = cyc + n;
        e.elapsed = el;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every rising timer_done must match the next scoreboard entry.
    always @(negedge clk) begin
        if (timer_done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: timer_done rose at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_elapsed"}, elapsed, e.elapsed);
            end
        end
        done_prev = timer_done;
    end

    initial begin
        reset       = 1'b1;
        timer_reset = 1'b1;
        period_in   = '0;
        period_load = 1'b0;

        // Reset state
        step(2);
        check("rst_done", timer_done, 0);
        check("rst_busy", busy, 0);
        check("rst_elapsed", elapsed, 0);
        reset = 1'b0;

        // Default interval: 3 ticks x 4 cycles = 12 edges
        step(5);
        check("clear_busy", busy, 0);
        timer_reset = 1'b0;
        expect_done("default", 12, DP);
        step(1);
        check("default_busy_first", busy, 1);
        check("default_done_first", timer_done, 0);
        step(10);
        check("default_done_at11", timer_done, 0);
        step(1);
        check("default_busy_exp", busy, 0);
        step(20);
        check("default_done_hold", timer_done, 1);
        check("default_elapsed_hold", elapsed, DP);

        // Mid-interval restart
        timer_reset = 1'b1;
        step(1);
        check("restart_clear_done", timer_done, 0);
        check("restart_clear_elapsed", elapsed, 0);
        step(2);
        timer_reset = 1'b0;
        step(7);
        check("restart_elapsed_mid", elapsed, 1);
        timer_reset = 1'b1;
        step(1);
        check("restart_elapsed_zero", elapsed, 0);
        check("restart_busy_zero", busy, 0);
        timer_reset = 1'b0;
        expect_done("restart", 12, DP);
        step(14);
        check("restart_done", timer_done, 1);

        // Period load 5 in CLEAR; load during RUN ignored
        timer_reset = 1'b1;
        step(1);
        period_in   = 8'd5;
        period_load = 1'b1;
        step(1);
        period_load = 1'b0;
        step(1);
        timer_reset = 1'b0;
        expect_done("period5", 20, 5);
        step(3);
        period_in   = 8'd2;
        period_load = 1'b1;
        step(1);
        period_load = 1'b0;
        step(20);
        check("period5_done", timer_done, 1);

        // Period 0 stored as 1
        timer_reset = 1'b1;
        step(1);
        period_in   = 8'd0;
        period_load = 1'b1;
        step(1);
        period_load = 1'b0;
        timer_reset = 1'b0;
        expect_done("period0", 4, 1);
        step(6);

        // Load on the same edge as CLEAR->RUN applies to this run
        timer_reset = 1'b1;
        step(1);
        period_in   = 8'd2;
        period_load = 1'b1;
        timer_reset = 1'b0;
        expect_done("load_on_start", 8, 2);
        step(1);
        period_load = 1'b0;
        step(10);

        // Async reset mid-RUN (period currently 2)
        timer_reset = 1'b1;
        step(1);
        timer_reset = 1'b0;
        step(5);
        check("arst_pre_busy", busy, 1);
        check("arst_pre_elapsed", elapsed, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_run_busy", busy, 0);
        check("arst_run_elapsed", elapsed, 0);
        check("arst_run_done", timer_done, 0);
        timer_reset = 1'b1;
        step(2);
        reset = 1'b0;
        // Period must be back to the default of 3
        timer_reset = 1'b0;
        expect_done("after_arst", 12, DP);
        step(13);
        check("after_arst_done", timer_done, 1);
        #3 reset = 1'b1;
        #1;
        check("arst_exp_done", timer_done, 0);
        check("arst_exp_elapsed", elapsed, 0);
        timer_reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);

        // Collision: timer_reset sampled high on the 12th edge
        timer_reset = 1'b0;
        step(11);
        check("coll_done_pre", timer_done, 0);
        timer_reset = 1'b1;
        step(1);
        check("coll_done", timer_done, 0);
        check("coll_busy", busy, 0);
        check("coll_elapsed", elapsed, 0);
        step(5);
        check("coll_done_later", timer_done, 0);

        step(2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_timer.md
Name: debounce_timer

Overview:
- Responder side of the debouncer FSM's timer handshake. It receives `timer_reset` from the FSM and returns `timer_done` once a programmable debounce interval has elapsed with `timer_reset` held low.
- It contains a cycle prescaler that produces interval ticks, plus a tick counter driven by a small FSM.
- It sits beside each debouncer FSM instance in the button path and replaces ad-hoc free-running counters.

Parameters:
- `CYCLES_PER_TICK`, default 100000: clock cycles per interval tick (1 ms at 100 MHz); must be ≥ 1.
- `PERIOD_W`, default 8: width of the period and elapsed-tick fields.
- `DEFAULT_PERIOD`, default 20: period in ticks loaded at reset (20 ms).

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset for all state.
- `timer_reset`, in, 1: from the FSM; high clears and holds the timer, low lets it run.
- `period_in`, in, `PERIOD_W`: new period in ticks.
- `period_load`, in, 1: one-cycle strobe that latches `period_in`.
- `timer_done`, out, 1: registered; high once the interval has elapsed, sticky until `timer_reset`.
- `busy`, out, 1: registered; high while counting (state RUN).
- `elapsed`, out, `PERIOD_W`: ticks completed in the current run (debug/status).

Behaviour:
- **Reset values:** `reset` high forces state=CLEAR, prescaler=0, tick count=0, period=`DEFAULT_PERIOD`, `timer_done`=0, `busy`=0, `elapsed`=0.
- **States:**
  - CLEAR: `timer_reset` high, or just released.
  - RUN: counting.
  - EXPIRED: interval elapsed.
- **Transitions**, evaluated each rising edge; `timer_reset` has highest priority:
  - Any state, `timer_reset`=1 → CLEAR. Prescaler and tick count zeroed, `timer_done`=0 on the next cycle.
  - CLEAR, `timer_reset`=0 → RUN. This edge counts as prescaler cycle 1.
  - RUN, `timer_reset`=0, final tick completes → EXPIRED, `timer_done`=1.
  - EXPIRED, `timer_reset`=0 → stays EXPIRED. Counters frozen, `timer_done` stays 1, no wrap-around.
- **Latency:** with P = effective period and N = P × `CYCLES_PER_TICK`, `timer_done` is high after exactly N consecutive rising edges that sampled `timer_reset`=0. Any `timer_reset`=1 sample restarts the count from zero.
- **Prescaler:**
  - Counts 0 … `CYCLES_PER_TICK`−1 while in RUN or on the CLEAR→RUN edge.
  - Terminal count produces a one-cycle tick and wraps to 0.
  - Width is ceil(log2(`CYCLES_PER_TICK`)), minimum 1.
- **Tick counter:**
  - Increments on each tick; `elapsed` mirrors it.
  - On the tick where count+1 == P, the state moves to EXPIRED.
- **Period load:**
  - Accepted only in CLEAR; ignored in RUN and EXPIRED, so the period never changes mid-interval.
  - A value of 0 is stored as 1.
  - If `period_load` and a CLEAR→RUN transition occur in the same cycle, the new value applies to this run.
- **Simultaneous events:** if the final tick and `timer_reset`=1 arrive in the same cycle, reset wins: state goes to CLEAR and `timer_done` stays 0.
- **Mid-operation reset:** asynchronous `reset` during RUN or EXPIRED returns every output to its reset value immediately. The period reverts to `DEFAULT_PERIOD`.
- **FSM compatibility:** the FSM holds `timer_reset` high in its idle and pressed states. `timer_done` is therefore always 0 on the first cycle of each FSM counting state.

Decomposition:
- **Shared package `debounce_pkg`:**
  - 2-bit state encoding: CLEAR=0, RUN=1, EXPIRED=2.
  - `DEFAULT_PERIOD` and `CYCLES_PER_TICK` defaults.
  - The ceil-log2 width helper.
- **Sub-module `tick_prescaler`:**
  - Parameter `CYCLES_PER_TICK`; inputs `clk`, `reset`, `clear`, `enable`; output `tick`.
  - `debounce_timer` instantiates it and keeps the FSM, period register and tick counter.

Test Plan (`CYCLES_PER_TICK`=4, `DEFAULT_PERIOD`=3, so N=12):
- **Default interval:** `reset` pulse, hold `timer_reset`=1 for 5 cycles, then drop it → `busy`=1 from the first edge; `timer_done` rises exactly after 12 edges with `timer_reset`=0; `elapsed`=3; state holds EXPIRED for 20 further cycles.
- **Mid-interval restart:** drop `timer_reset`, raise it after 7 edges for 1 cycle, drop it again → `timer_done` 0 until 12 edges after the second drop; `elapsed` returns to 0 during the reset cycle.
- **Period load:** in CLEAR, `period_load`=1 with `period_in`=5 → next run asserts `timer_done` after 20 edges. `period_load`=1 with `period_in`=2 during RUN → ignored, still 20. `period_in`=0 loaded in CLEAR → next run asserts after 4 edges.
- **Collision:** assert `timer_reset`=1 on the edge where the 12th cycle completes → `timer_done` never asserts; state CLEAR.
- **Async reset:** assert `reset` asynchronously mid-RUN and in EXPIRED → `timer_done`, `busy`, `elapsed` drop to 0 without waiting for a clock edge; the period returns to 3.
- **Closed loop:** connect to the debouncer FSM, drive a noisy input with bounces shorter than 12 cycles, then a stable high for 30 cycles → debounced output rises once, exactly 12 edges after the last bounce; identical behaviour on release.
